univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_pkg.sv | 21 ++
 rtl/hex7seg.sv | 30 +++
 rtl/univ_shift_reg.sv | 120 ++++++++++++
 tb/tb_univ_shift_reg.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// rtl/univ_shift_pkg.sv - shared mode and controller state types for univ_shift_reg
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROTL = 3'd4,
    MODE_ROTR = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_CLR  = 3'd7
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex digit to seven-segment decode (bit0=a .. bit6=g)
module hex7seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_nibble)
      4'h0: o_seg = 7'h3F;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with single-step and counted burst operation
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done,
  output logic [7:0]       seg
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  shift_mode_t      r_mode;
  shift_mode_t      w_mode_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;
  logic             w_apply;
  logic             w_latch;
  logic [6:0]       w_seg7;

  // start wins over en while idle; during a burst the live mode input is replaced by the latched one
  always_comb begin
    w_next_state = r_state;
    w_apply      = 1'b0;
    w_latch      = 1'b0;
    w_mode_sel   = shift_mode_t'(mode);
    case (r_state)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            w_next_state = SHIFT;
            w_latch      = 1'b1;
          end else begin
            w_next_state = DONE;
          end
        end else if (en) begin
          w_apply = 1'b1;
        end
      end
      SHIFT: begin
        w_apply    = 1'b1;
        w_mode_sel = r_mode;
        if (r_cnt == CNT_ONE) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    w_shifted = r_q;
    case (w_mode_sel)
      MODE_HOLD: w_shifted = r_q;
      MODE_LOAD: w_shifted = par_in;
      MODE_SHL:  w_shifted = {r_q[WIDTH-2:0], ser_in_r};
      MODE_SHR:  w_shifted = {ser_in_l, r_q[WIDTH-1:1]};
      MODE_ROTL: w_shifted = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      MODE_ROTR: w_shifted = {r_q[0], r_q[WIDTH-1:1]};
      MODE_ASR:  w_shifted = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      MODE_CLR:  w_shifted = '0;
      default:   w_shifted = r_q;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_HOLD;
    end else begin
      r_state <= w_next_state;
      if (w_apply) begin
        r_q <= w_shifted;
      end
      if (w_latch) begin
        r_cnt  <= burst_len;
        r_mode <= w_mode_sel;
      end else if (r_state == SHIFT) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  hex7seg u_hex7seg (
    .i_nibble (r_q[3:0]),
    .o_seg    (w_seg7)
  );

  assign q         = r_q;
  assign ser_out_l = r_q[WIDTH-1];
  assign ser_out_r = r_q[0];
  assign busy      = (r_state == SHIFT);
  assign done      = (r_state == DONE);
  assign seg       = {busy, w_seg7};

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg against a behavioural model
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_ROTL = 3'd4;
  localparam logic [2:0] M_ROTR = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;
  localparam logic [2:0] M_CLR  = 3'd7;

  logic             clk_2     = 1'b0;
  logic             reset     = 1'b0;
  logic             en        = 1'b0;
  logic [2:0]       mode      = 3'd0;
  logic             ser_in_l  = 1'b0;
  logic             ser_in_r  = 1'b0;
  logic [WIDTH-1:0] par_in    = '0;
  logic             start     = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic [WIDTH-1:0] q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;
  logic [7:0]       seg;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model: register value, shifts still owed in the current burst, pending done pulse
  logic [7:0] m_q    = 8'h00;
  int         m_left = 0;
  logic [2:0] m_mode = 3'd0;
  logic       m_done = 1'b0;

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .par_in    (par_in),
    .start     (start),
    .burst_len (burst_len),
    .q         (q),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .busy      (busy),
    .done      (done),
    .seg       (seg)
  );

  always #5 clk_2 = ~clk_2;

  function automatic logic [7:0] apply(input logic [2:0] md, input logic [7:0] cur,
                                       input logic [7:0] pin, input logic sl, input logic sr);
    logic [7:0] r;
    case (md)
      3'd0: r = cur;
      3'd1: r = pin;
      3'd2: r = (cur << 1) | {7'd0, sr};
      3'd3: r = (cur >> 1) | {sl, 7'd0};
      3'd4: r = (cur << 1) | (cur >> 7);
      3'd5: r = (cur >> 1) | (cur << 7);
      3'd6: r = 8'($signed(cur) >>> 1);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      m_q    = 8'h00;
      m_left = 0;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_q    = apply(m_mode, m_q, par_in, ser_in_l, ser_in_r);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      if (burst_len != 0) begin
        m_mode = mode;
        m_left = int'(burst_len);
      end else begin
        m_done = 1'b1;
      end
    end else if (en) begin
      m_q = apply(mode, m_q, par_in, ser_in_l, ser_in_r);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk_2) begin
    if (chk_on) begin
      chk("model_q", 32'(q), 32'(m_q));
      chk("model_busy", 32'(busy), 32'(m_left > 0));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_ser_out_l", 32'(ser_out_l), 32'(m_q[7]));
      chk("model_ser_out_r", 32'(ser_out_r), 32'(m_q[0]));
      chk("model_seg", 32'(seg), 32'({m_left > 0, seg_tbl[m_q[3:0]]}));
    end
  end

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    mode   = M_LOAD;
    par_in = v;
    en     = 1'b1;
    tick();
    en     = 1'b0;
    mode   = M_HOLD;
  endtask

  task automatic wait_burst(output int c);
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      tick();
      c++;
    end
  endtask

  int c;

  initial begin
    #22;
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_seg", 32'(seg), 32'h3F);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset  = 1'b1;
    chk_on = 1'b1;

    load(8'hA5);
    chk("load_a5", 32'(q), 32'hA5);
    mode = M_SHL; ser_in_r = 1'b1; en = 1'b1;
    tick();
    chk("shl_q", 32'(q), 32'h4B);
    chk("shl_ser_out_l", 32'(ser_out_l), 32'd0);
    en = 1'b0; ser_in_r = 1'b0;

    for (int m = 0; m < 8; m++) begin
      load(8'h96);
      mode = 3'(m); ser_in_l = 1'b1; ser_in_r = m[0]; en = 1'b1;
      tick();
      en = 1'b0;
      mode = M_CLR;
      tick();
    end
    ser_in_l = 1'b0; ser_in_r = 1'b0;

    load(8'h81);
    mode = M_ROTR; burst_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; mode = M_HOLD;
    chk("rotr_busy_start", 32'(busy), 32'd1);
    wait_burst(c);
    chk("rotr_cycles", 32'(c), 32'd3);
    chk("rotr_q", 32'(q), 32'h30);
    chk("rotr_done", 32'(done), 32'd1);
    tick();
    chk("rotr_done_pulse", 32'(done), 32'd0);

    load(8'h80);
    mode = M_ASR; burst_len = 4'd9; start = 1'b1;
    tick();
    start = 1'b0; mode = M_HOLD;
    wait_burst(c);
    chk("asr_cycles", 32'(c), 32'd9);
    chk("asr_q", 32'(q), 32'hFF);
    chk("asr_done", 32'(done), 32'd1);
    tick();

    mode = M_CLR; en = 1'b1; burst_len = 4'd0; start = 1'b1;
    tick();
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_q", 32'(q), 32'hFF);
    burst_len = 4'd2;
    tick();
    start = 1'b0; en = 1'b0;
    chk("done_ignores_start_busy", 32'(busy), 32'd0);
    chk("done_ignores_start_q", 32'(q), 32'hFF);
    tick();

    mode = M_LOAD; par_in = 8'h11; burst_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; mode = M_HOLD;
    par_in = 8'h22; tick();
    par_in = 8'h33; tick();
    par_in = 8'h44; tick();
    chk("load_burst_q", 32'(q), 32'h44);
    tick();
    mode = M_CLR; burst_len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0; mode = M_HOLD;
    wait_burst(c);
    chk("clr_burst_q", 32'(q), 32'h00);
    tick();

    load(8'h3C);
    mode = M_ROTL; burst_len = 4'd5; start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      mode = 3'(i * 3); en = i[0]; start = ~i[0]; burst_len = 4'(i + 1);
      tick();
    end
    chk("toggle_burst_q", 32'(q), 32'h87);
    chk("toggle_burst_done", 32'(done), 32'd1);
    start = 1'b0; en = 1'b0; mode = M_HOLD;
    tick();

    load(8'h3C);
    mode = M_ROTL; burst_len = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; mode = M_HOLD;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_q", 32'(q), 32'h00);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    #3 reset = 1'b1;
    tick();
    chk("no_done_after_reset_1", 32'(done), 32'd0);
    tick();
    chk("no_done_after_reset_2", 32'(done), 32'd0);

    for (int v = 0; v < 16; v++) begin
      load({4'h5, 4'(v)});
      chk("seg_sweep", 32'(seg), 32'({1'b0, seg_tbl[v]}));
    end

    load(8'h5A);
    mode = M_ROTL; burst_len = 4'd4; start = 1'b1;
    tick();
    start = 1'b0; mode = M_HOLD;
    chk("seg_dp_busy", 32'(seg[7]), 32'd1);
    wait_burst(c);
    chk("seg_dp_idle", 32'(seg[7]), 32'd0);
    chk("rotl4_q", 32'(q), 32'hA5);
    tick();
    tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
